// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory access controller.
// The memory is 256 x 32, word-addressed by byte-address bits [9:2].
package imem_pkg;

  localparam int          DEPTH      = 256;
  localparam int          IMEM_IDX_W = 8;
  localparam int          IDX_MSB    = 9;
  localparam int          IDX_LSB    = 2;
  localparam int          LD_CNT_W   = 9;
  localparam logic [31:0] BOOT_PC    = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;

  localparam logic [LD_CNT_W-1:0] LD_CNT_MAX = LD_CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/imem_fetch_seq.sv
// PC-sequential fetch engine: request PC, stall hold, redirect squash and the
// response bookkeeping for a memory with one cycle of read latency.
module imem_fetch_seq
  import imem_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        flush,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] target,
  input  logic [31:0] mem_rdata,
  output logic [31:0] req_pc,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic        if_valid,
  output logic        err_misaligned
);

  logic        rsp_valid;
  logic [31:0] rsp_pc;
  logic        held;
  logic        held_valid;
  logic [31:0] held_pc;
  logic [31:0] held_instr;

  // While held, the memory already returns the next word, so the displayed
  // word comes from the capture registers instead of mem_rdata.
  always_comb begin
    if (held) begin
      if_valid = held_valid;
      if_pc    = held_pc;
      if_instr = held_instr;
    end else begin
      if_valid = rsp_valid;
      if_pc    = rsp_pc;
      if_instr = rsp_valid ? mem_rdata : NOP_INSTR;
    end
  end

  // NOTE: sequential state is written only with non-blocking assignments so
  // every register samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_pc         <= BOOT_PC;
      rsp_valid      <= 1'b0;
      rsp_pc         <= '0;
      held           <= 1'b0;
      held_valid     <= 1'b0;
      held_pc        <= '0;
      held_instr     <= NOP_INSTR;
      err_misaligned <= 1'b0;
    end else if (!en || flush) begin
      req_pc    <= BOOT_PC;
      rsp_valid <= 1'b0;
      held      <= 1'b0;
    end else if (redirect) begin
      req_pc    <= {target[31:2], 2'b00};
      rsp_valid <= 1'b0;
      held      <= 1'b0;
      if (target[1:0] != 2'b00) err_misaligned <= 1'b1;
    end else if (stall) begin
      held       <= 1'b1;
      held_valid <= if_valid;
      held_pc    <= if_pc;
      held_instr <= if_instr;
    end else begin
      req_pc    <= req_pc + 32'd4;
      rsp_valid <= 1'b1;
      rsp_pc    <= req_pc;
      held      <= 1'b0;
    end
  end

endmodule

// File: rtl/imem_access_ctrl.sv
// Instruction-memory port owner: arbitrates the CPU fetch stream against a
// program loader, which has priority and holds the CPU while it runs.
module imem_access_ctrl
  import imem_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  if_stall,
  input  logic                  if_redirect,
  input  logic [31:0]           if_target,
  output logic [31:0]           if_pc,
  output logic [31:0]           if_instr,
  output logic                  if_valid,
  output logic                  cpu_hold,
  input  logic                  ld_start,
  input  logic                  ld_valid,
  output logic                  ld_ready,
  input  logic [31:0]           ld_addr,
  input  logic [31:0]           ld_data,
  input  logic                  ld_done,
  output logic [LD_CNT_W-1:0]   ld_count,
  output logic [IMEM_IDX_W-1:0] mem_addr,
  output logic                  mem_we,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata,
  output logic                  err_misaligned
);

  state_e      state_q;
  state_e      state_d;
  logic [31:0] req_pc;
  logic        ld_write;
  logic        unused_bits;

  assign unused_bits = ^{ld_addr[31:IDX_MSB+1], ld_addr[IDX_LSB-1:0],
                         req_pc[31:IDX_MSB+1], req_pc[IDX_LSB-1:0]};

  imem_fetch_seq u_fetch (
    .clk            (clk),
    .rst_n          (rst_n),
    .en             (state_q == FETCH),
    .flush          (ld_start),
    .stall          (if_stall),
    .redirect       (if_redirect),
    .target         (if_target),
    .mem_rdata      (mem_rdata),
    .req_pc         (req_pc),
    .if_pc          (if_pc),
    .if_instr       (if_instr),
    .if_valid       (if_valid),
    .err_misaligned (err_misaligned)
  );

  // NOTE: every combinational output gets a default first, so no path
  // through the case statement can leave a latch behind.
  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:   if (ld_start) state_d = LOAD;
      LOAD:    if (ld_done)  state_d = DRAIN;
      DRAIN:   state_d = FETCH;
      default: state_d = FETCH;
    endcase
  end

  assign ld_write  = (state_q == LOAD) && ld_valid;
  assign cpu_hold  = (state_q != FETCH);
  assign ld_ready  = (state_q == LOAD);
  assign mem_we    = ld_write;
  assign mem_wdata = ld_write ? ld_data : '0;
  assign mem_addr  = (state_q == LOAD) ? ld_addr[IDX_MSB:IDX_LSB]
                                       : req_pc[IDX_MSB:IDX_LSB];

  // NOTE: the instruction memory itself is never reset; a reset only aborts
  // the session, so words written before it survive.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= FETCH;
      ld_count <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == FETCH && ld_start) begin
        ld_count <= '0;
      end else if (ld_write && ld_count != LD_CNT_MAX) begin
        ld_count <= ld_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_imem_access_ctrl.sv
// Scoreboard bench for imem_access_ctrl with a registered-read memory model.
module tb_imem_access_ctrl;
  import imem_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        if_stall;
  logic        if_redirect;
  logic [31:0] if_target;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_valid;
  logic        cpu_hold;
  logic        ld_start;
  logic        ld_valid;
  logic        ld_ready;
  logic [31:0] ld_addr;
  logic [31:0] ld_data;
  logic        ld_done;
  logic [8:0]  ld_count;
  logic [7:0]  mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        err_misaligned;

  typedef struct {
    logic        v;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        hold;
    logic        ready;
    logic        we;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic        err;
    logic [8:0]  cnt;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] mem     [DEPTH];
  logic [31:0] ref_mem [DEPTH];
  logic        exp_err;
  logic [8:0]  exp_cnt;

  imem_access_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .if_stall       (if_stall),
    .if_redirect    (if_redirect),
    .if_target      (if_target),
    .if_pc          (if_pc),
    .if_instr       (if_instr),
    .if_valid       (if_valid),
    .cpu_hold       (cpu_hold),
    .ld_start       (ld_start),
    .ld_valid       (ld_valid),
    .ld_ready       (ld_ready),
    .ld_addr        (ld_addr),
    .ld_data        (ld_data),
    .ld_done        (ld_done),
    .ld_count       (ld_count),
    .mem_addr       (mem_addr),
    .mem_we         (mem_we),
    .mem_wdata      (mem_wdata),
    .mem_rdata      (mem_rdata),
    .err_misaligned (err_misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check("if_valid", {31'd0, if_valid}, {31'd0, e.v});
      check("if_instr", if_instr, e.instr);
      if (e.v) check("if_pc", if_pc, e.pc);
      check("cpu_hold", {31'd0, cpu_hold}, {31'd0, e.hold});
      check("ld_ready", {31'd0, ld_ready}, {31'd0, e.ready});
      check("mem_we", {31'd0, mem_we}, {31'd0, e.we});
      check("err_misaligned", {31'd0, err_misaligned}, {31'd0, e.err});
      check("ld_count", {23'd0, ld_count}, {23'd0, e.cnt});
      if (e.we) begin
        check("mem_addr", {24'd0, mem_addr}, {24'd0, e.addr});
        check("mem_wdata", mem_wdata, e.wdata);
      end
    end
  end

  function automatic exp_t fe(input logic v, input logic [31:0] pc);
    exp_t e;
    e.v     = v;
    e.pc    = pc;
    e.instr = v ? ref_mem[pc[9:2]] : NOP_INSTR;
    e.hold  = 1'b0;
    e.ready = 1'b0;
    e.we    = 1'b0;
    e.addr  = '0;
    e.wdata = '0;
    e.err   = exp_err;
    e.cnt   = exp_cnt;
    return e;
  endfunction

  function automatic exp_t le(input logic we, input logic ready, input logic [31:0] addr,
                              input logic [31:0] data);
    exp_t e;
    e       = fe(1'b0, 32'd0);
    e.hold  = 1'b1;
    e.ready = ready;
    e.we    = we;
    e.addr  = addr[9:2];
    e.wdata = data;
    return e;
  endfunction

  task automatic clr();
    if_stall    = 1'b0;
    if_redirect = 1'b0;
    if_target   = '0;
    ld_start    = 1'b0;
    ld_valid    = 1'b0;
    ld_addr     = '0;
    ld_data     = '0;
    ld_done     = 1'b0;
  endtask

  task automatic tick(input exp_t e);
    sb_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic ld_write(input logic [31:0] addr, input logic [31:0] data, input logic done);
    ld_valid = 1'b1;
    ld_addr  = addr;
    ld_data  = data;
    ld_done  = done;
    tick(le(1'b1, 1'b1, addr, data));
    ref_mem[addr[9:2]] = data;
    if (exp_cnt != 9'd256) exp_cnt++;
    clr();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_if_valid"}, {31'd0, if_valid}, 32'd0);
    check({tag, "_if_instr"}, if_instr, NOP_INSTR);
    check({tag, "_if_pc"}, if_pc, 32'd0);
    check({tag, "_cpu_hold"}, {31'd0, cpu_hold}, 32'd0);
    check({tag, "_ld_ready"}, {31'd0, ld_ready}, 32'd0);
    check({tag, "_mem_we"}, {31'd0, mem_we}, 32'd0);
    check({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    check({tag, "_mem_addr"}, {24'd0, mem_addr}, 32'd0);
    check({tag, "_ld_count"}, {23'd0, ld_count}, 32'd0);
    check({tag, "_err"}, {31'd0, err_misaligned}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      mem[i]     = 32'h1000_0000 | i;
      ref_mem[i] = 32'h1000_0000 | i;
    end
    mem[0] = 32'h00A0_0093;  ref_mem[0] = 32'h00A0_0093;
    mem[3] = 32'h0020_8233;  ref_mem[3] = 32'h0020_8233;
    mem[7] = 32'h0080_03EF;  ref_mem[7] = 32'h0080_03EF;
    exp_err = 1'b0;
    exp_cnt = '0;
    clr();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");

    // Sequential fetch from BOOT_PC; first valid word in the second cycle.
    rst_n = 1'b1;
    tick(fe(1'b0, 32'd0));
    for (int i = 0; i < 9; i++) tick(fe(1'b1, 32'(i * 4)));
    if_redirect = 1'b1; if_target = 32'h04;
    tick(fe(1'b1, 32'h24));
    clr();
    tick(fe(1'b0, 32'd0));
    tick(fe(1'b1, 32'h04));
    tick(fe(1'b1, 32'h08));

    // Three stall cycles while 0x0C is shown.
    if_stall = 1'b1;
    repeat (3) tick(fe(1'b1, 32'h0C));
    clr();
    tick(fe(1'b1, 32'h0C));
    tick(fe(1'b1, 32'h10));

    // Plain redirect, then redirect combined with stall.
    if_redirect = 1'b1; if_target = 32'h1C;
    tick(fe(1'b1, 32'h14));
    clr();
    tick(fe(1'b0, 32'd0));
    tick(fe(1'b1, 32'h1C));
    tick(fe(1'b1, 32'h20));
    if_redirect = 1'b1; if_target = 32'h0C; if_stall = 1'b1;
    tick(fe(1'b1, 32'h24));
    clr();
    tick(fe(1'b0, 32'd0));
    tick(fe(1'b1, 32'h0C));

    // Misaligned target: sticky error, fetch from the aligned word.
    if_redirect = 1'b1; if_target = 32'h22;
    tick(fe(1'b1, 32'h10));
    clr();
    exp_err = 1'b1;
    tick(fe(1'b0, 32'd0));
    tick(fe(1'b1, 32'h20));
    tick(fe(1'b1, 32'h24));

    // Wrap past the top word back to index 0.
    if_redirect = 1'b1; if_target = 32'h3FC;
    tick(fe(1'b1, 32'h28));
    clr();
    tick(fe(1'b0, 32'd0));
    tick(fe(1'b1, 32'h3FC));
    tick(fe(1'b1, 32'h400));
    tick(fe(1'b1, 32'h404));

    // Load session: four writes, the last one alongside ld_done.
    ld_start = 1'b1;
    tick(fe(1'b1, 32'h408));
    clr();
    exp_cnt = '0;
    ld_write(32'h00, 32'hDEAD_BEEF, 1'b0);
    if_redirect = 1'b1; if_target = 32'h40; if_stall = 1'b1; ld_start = 1'b1;
    tick(le(1'b0, 1'b1, 32'd0, 32'd0));
    clr();
    ld_write(32'h04, 32'hDEAD_BEEF + 32'd1, 1'b0);
    ld_write(32'h08, 32'hDEAD_BEEF + 32'd2, 1'b0);
    ld_write(32'h0C, 32'hDEAD_BEEF + 32'd3, 1'b1);
    tick(le(1'b0, 1'b0, 32'd0, 32'd0));
    tick(fe(1'b0, 32'd0));
    tick(fe(1'b1, 32'h00));
    tick(fe(1'b1, 32'h04));

    // Asynchronous reset in the middle of a second load session.
    ld_start = 1'b1;
    tick(fe(1'b1, 32'h08));
    clr();
    exp_cnt = '0;
    ld_write(32'h00, 32'hCAFE_0000, 1'b0);
    ld_write(32'h04, 32'hCAFE_0001, 1'b0);
    ld_valid = 1'b1; ld_addr = 32'h08; ld_data = 32'h1234_5678;
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    clr();
    @(posedge clk);
    #1;
    rst_n   = 1'b1;
    exp_err = 1'b0;
    exp_cnt = '0;
    tick(fe(1'b0, 32'd0));
    tick(fe(1'b1, 32'h00));
    tick(fe(1'b1, 32'h04));
    tick(fe(1'b1, 32'h08));

    @(negedge clk);
    if (sb_q.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/imem_access_ctrl.md
Name: imem_access_ctrl

Overview:
Sequences all accesses to the single-port, word-aligned 256 x 32 instruction memory. It owns the memory address/write port and arbitrates between the CPU fetch stream and a program loader. The loader (UART/debug) has priority, and while it runs the CPU is held. In fetch mode the block issues PC-sequential reads, honours IF-stage stall and branch/jump redirects, and squashes in-flight words on redirect.

Parameters:
DEPTH, 256, number of 32-bit words in instruction memory; index is addr[9:2]
BOOT_PC, 32'h00000000, fetch restart address after reset and after a load session
NOP_INSTR, 32'h00000013, value driven on if_instr when if_valid=0 (addi x0,x0,0)

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
if_stall  in  1  IF/ID hazard stall; hold current fetch
if_redirect  in  1  taken branch/jal from EX; squash and refetch
if_target  in  32  redirect byte address
if_pc  out  32  byte address of word on if_instr
if_instr  out  32  fetched instruction
if_valid  out  1  if_instr/if_pc valid this cycle
cpu_hold  out  1  high while loading; freezes pipeline
ld_start  in  1  pulse: enter load session
ld_valid  in  1  loader write request
ld_ready  out  1  controller accepts loader write
ld_addr  in  32  loader byte address
ld_data  in  32  loader write data
ld_done  in  1  pulse: end load session
ld_count  out  9  words written in current/last session
mem_addr  out  8  memory word index
mem_we  out  1  memory write enable
mem_wdata  out  32  memory write data
mem_rdata  in  32  memory read data, registered: valid one cycle after mem_addr
err_misaligned  out  1  sticky; set by redirect target with bits[1:0] != 0

Behaviour:
- Reset (async assert, sync release): state=FETCH, req_pc=BOOT_PC, if_valid=0, if_instr=NOP_INSTR, if_pc=0, cpu_hold=0, ld_ready=0, mem_we=0, mem_wdata=0, ld_count=0, err_misaligned=0.
- States: FETCH, LOAD, DRAIN.
- FETCH: mem_addr=req_pc[9:2], mem_we=0. Response one cycle later: if_instr=mem_rdata, if_pc=pc of that request, if_valid=1. Without stall, req_pc += 4 every cycle. First valid word appears in the 2nd cycle after reset release.
- Addresses wrap modulo DEPTH*4 via [9:2]; no range error.
- Stall: req_pc held and same address reissued; if_pc/if_instr/if_valid held unchanged.
- Redirect (has priority over stall): the in-flight response is squashed, so if_valid=0 and if_instr=NOP_INSTR next cycle. Then req_pc = {if_target[31:2],2'b00}; word from target is valid the cycle after. Bits[1:0] != 0 sets err_misaligned, cleared only by reset.
- ld_start in FETCH (priority over redirect and stall) -> LOAD next cycle. The in-flight fetch is discarded and ld_count is cleared.
- LOAD: cpu_hold=1, if_valid=0, ld_ready=1. When ld_valid is high, mem_addr=ld_addr[9:2], mem_we=1, mem_wdata=ld_data combinationally in the same cycle, and ld_count += 1 (saturates at 256). ld_start, if_redirect and if_stall are ignored.
- ld_done -> DRAIN. If ld_valid is high in the same cycle, the write is still performed and counted.
- DRAIN (1 cycle): cpu_hold=1, ld_ready=0, no access. Next state is FETCH with req_pc=BOOT_PC. cpu_hold drops when FETCH is entered.
- Reset mid-load: the session is aborted. Memory contents already written are retained (memory is not reset) and ld_count=0.

Decomposition:
- Shared package imem_pkg holds:
  - state enum (FETCH/LOAD/DRAIN)
  - NOP_INSTR, BOOT_PC and DEPTH constants
  - IMEM_IDX_W=8 and the index slice [9:2]
- One natural sub-module: imem_fetch_seq. It owns req_pc, stall/redirect/squash and the response register, and is enabled by the top FSM.
- The top-level block keeps the mode FSM, loader handshake, port mux and ld_count.

Test Plan:
- Reset release, no stall, memory preloaded with words 0..9 -> if_valid rises in cycle 2; if_pc 0x00,0x04,...,0x24 on consecutive cycles; if_instr[0]=32'h00A00093.
- if_stall for 3 cycles while if_pc=0x0C -> if_pc=0x0C and if_instr=32'h00208233 held for 3 cycles; sequence resumes at 0x10.
- if_redirect with if_target=0x1C while if_pc=0x14 -> one cycle if_valid=0/NOP; next word if_pc=0x1C, if_instr=32'h008003EF; if_redirect together with if_stall behaves identically.
- if_target=0x22 -> err_misaligned=1 and stays set; fetch resumes at 0x20.
- ld_start, then 4 writes to 0x00..0x0C with 32'hDEADBEEF+i (one with ld_done in the same cycle) -> mem_we pulses 4 times, ld_count=4, cpu_hold high through DRAIN; fetch restarts at 0x00 returning 32'hDEADBEEF.
- rst_n asserted asynchronously mid-LOAD after 2 writes -> all outputs at reset values immediately; after release, fetch at 0x00 returns the newly written word.
